// File: rtl/mem_bus_pkg.sv
// Shared types for the two-master memory bus arbiter.
package mem_bus_pkg;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_DBG  = 1'b1
    } owner_e;

    typedef enum logic [1:0] {
        ARB_IDLE     = 2'd0,
        ARB_OWN_CORE = 2'd1,
        ARB_OWN_DBG  = 2'd2,
        ARB_LOCKED   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Two-way winner pick: sole requester wins; on contention either debug
// (fixed priority) or whichever requester did not win last time.
module mem_bus_rr_pick
    import mem_bus_pkg::*;
#(
    parameter int DBG_PRIORITY = 0
) (
    input  logic   i_core_req,
    input  logic   i_dbg_req,
    input  owner_e i_last_winner,
    output logic   o_valid,
    output owner_e o_winner
);

    // Combinational winner selection
    always_comb begin
        o_valid  = i_core_req | i_dbg_req;
        o_winner = OWNER_CORE;
        if (i_dbg_req && !i_core_req) begin
            o_winner = OWNER_DBG;
        end else if (i_dbg_req && i_core_req) begin
            if (DBG_PRIORITY != 0) begin
                o_winner = OWNER_DBG;
            end else begin
                o_winner = (i_last_winner == OWNER_CORE) ? OWNER_DBG : OWNER_CORE;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the core (requester 0) and the debug
// system-bus engine (requester 1). A grant is held until the slave completes;
// the debug side can lock the bus across several accesses.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int DBG_PRIORITY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_read,
    input  logic                    core_write,
    input  logic [ADDR_WIDTH-1:0]   core_addr,
    input  logic [DATA_WIDTH-1:0]   core_wdata,
    input  logic [DATA_WIDTH/8-1:0] core_be,
    output logic [DATA_WIDTH-1:0]   core_rdata,
    output logic                    core_complete_read,
    output logic                    core_complete_write,
    input  logic                    dbg_read,
    input  logic                    dbg_write,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    input  logic [DATA_WIDTH-1:0]   dbg_wdata,
    input  logic [DATA_WIDTH/8-1:0] dbg_be,
    input  logic                    dbg_lock,
    output logic [DATA_WIDTH-1:0]   dbg_rdata,
    output logic                    dbg_complete_read,
    output logic                    dbg_complete_write,
    output logic                    dbg_granted,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    input  logic                    mem_complete_read,
    input  logic                    mem_complete_write
);

    arb_state_e r_state, w_state_nxt;
    owner_e     r_last, w_last_nxt;
    logic       w_pick_valid;
    owner_e     w_pick;
    logic       w_sel_valid;
    owner_e     w_sel;
    logic       w_done;

    mem_bus_rr_pick #(.DBG_PRIORITY(DBG_PRIORITY)) u_pick (
        .i_core_req    (core_read | core_write),
        .i_dbg_req     (dbg_read | dbg_write),
        .i_last_winner (r_last),
        .o_valid       (w_pick_valid),
        .o_winner      (w_pick)
    );

    // State and last-winner registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_IDLE;
            r_last  <= OWNER_DBG;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Current bus owner: arbitrated in IDLE, fixed while owned, debug-only when locked
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = OWNER_CORE;
        case (r_state)
            ARB_IDLE:     begin w_sel_valid = w_pick_valid;         w_sel = w_pick;    end
            ARB_OWN_CORE: begin w_sel_valid = 1'b1;                 w_sel = OWNER_CORE; end
            ARB_OWN_DBG:  begin w_sel_valid = 1'b1;                 w_sel = OWNER_DBG; end
            ARB_LOCKED:   begin w_sel_valid = dbg_read | dbg_write; w_sel = OWNER_DBG; end
            default:      begin w_sel_valid = 1'b0;                 w_sel = OWNER_CORE; end
        endcase
        // Keep every output quiet while reset is held, even if requests are up
        if (!rst_n) w_sel_valid = 1'b0;
        w_done = w_sel_valid & (mem_complete_read | mem_complete_write);
    end

    // Next state: a completing access releases to IDLE (or LOCKED for a locking debug owner)
    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        if (w_sel_valid) begin
            if (w_done) begin
                w_state_nxt = (w_sel == OWNER_DBG && dbg_lock) ? ARB_LOCKED : ARB_IDLE;
                w_last_nxt  = w_sel;
            end else begin
                w_state_nxt = (w_sel == OWNER_DBG) ? ARB_OWN_DBG : ARB_OWN_CORE;
            end
        end else if (r_state == ARB_LOCKED && !dbg_lock) begin
            w_state_nxt = ARB_IDLE;
        end
    end

    // Bus mux and response steering; read wins over a simultaneous write
    always_comb begin
        mem_read            = 1'b0;
        mem_write           = 1'b0;
        mem_addr            = '0;
        mem_wdata           = '0;
        mem_be              = '0;
        core_rdata          = '0;
        core_complete_read  = 1'b0;
        core_complete_write = 1'b0;
        dbg_rdata           = '0;
        dbg_complete_read   = 1'b0;
        dbg_complete_write  = 1'b0;
        if (w_sel_valid && w_sel == OWNER_CORE) begin
            mem_read            = core_read;
            mem_write           = core_write & ~core_read;
            mem_addr            = core_addr;
            mem_wdata           = core_wdata;
            mem_be              = core_be;
            core_complete_read  = mem_complete_read;
            core_complete_write = mem_complete_write;
            core_rdata          = mem_complete_read ? mem_rdata : '0;
        end else if (w_sel_valid) begin
            mem_read            = dbg_read;
            mem_write           = dbg_write & ~dbg_read;
            mem_addr            = dbg_addr;
            mem_wdata           = dbg_wdata;
            mem_be              = dbg_be;
            dbg_complete_read   = mem_complete_read;
            dbg_complete_write  = mem_complete_write;
            dbg_rdata           = mem_complete_read ? mem_rdata : '0;
        end
    end

    assign dbg_granted = (r_state == ARB_OWN_DBG) || (r_state == ARB_LOCKED);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: DUT 0 is round-robin, DUT 1 is debug-priority.
module tb_mem_bus_arbiter;

    typedef struct packed {
        logic        crd, cwr;
        logic [31:0] caddr, cwdata;
        logic [3:0]  cbe;
        logic        drd, dwr;
        logic [31:0] daddr, dwdata;
        logic [3:0]  dbe;
        logic        dlock;
        logic [31:0] mrdata;
        logic        mcr, mcw;
    } in_t;

    typedef struct packed {
        logic        mrd, mwr;
        logic [31:0] maddr, mwdata;
        logic [3:0]  mbe;
        logic [31:0] crdata;
        logic        ccr, ccw;
        logic [31:0] drdata;
        logic        dcr, dcw, dg;
    } out_t;

    typedef struct { in_t i; out_t o; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  di [2];
    out_t dq [2];
    int   n_chk = 0, n_pass = 0;

    // Reference model state per DUT: owner (-1 none, 0 core, 1 dbg), lock hold, last winner
    int   m_own [2];
    bit   m_lk  [2];
    int   m_last[2];
    in_t  rx    [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DBG_PRIORITY(g)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .core_read(di[g].crd), .core_write(di[g].cwr), .core_addr(di[g].caddr),
            .core_wdata(di[g].cwdata), .core_be(di[g].cbe),
            .core_rdata(dq[g].crdata), .core_complete_read(dq[g].ccr),
            .core_complete_write(dq[g].ccw),
            .dbg_read(di[g].drd), .dbg_write(di[g].dwr), .dbg_addr(di[g].daddr),
            .dbg_wdata(di[g].dwdata), .dbg_be(di[g].dbe), .dbg_lock(di[g].dlock),
            .dbg_rdata(dq[g].drdata), .dbg_complete_read(dq[g].dcr),
            .dbg_complete_write(dq[g].dcw), .dbg_granted(dq[g].dg),
            .mem_read(dq[g].mrd), .mem_write(dq[g].mwr), .mem_addr(dq[g].maddr),
            .mem_wdata(dq[g].mwdata), .mem_be(dq[g].mbe),
            .mem_rdata(di[g].mrdata), .mem_complete_read(di[g].mcr),
            .mem_complete_write(di[g].mcw)
        );
    end

    task automatic chk(input string nm, input int k, input out_t got, input out_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, k, $time, got, exp);
    endtask

    task automatic chk_b(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s dut%0d t=%0t got=%h exp=%h", nm, k, $time, got, exp);
    endtask

    // Bus ownership model: who holds the bus this cycle and what each port should see
    function automatic out_t mdl(input in_t x, input int own, input bit lk, input int last,
                                 input int prio, output int sel);
        out_t o  = '0;
        bit   cr = x.crd | x.cwr;
        bit   dr = x.drd | x.dwr;
        if (own >= 0)       sel = own;
        else if (lk)        sel = dr ? 1 : -1;
        else if (cr && dr)  sel = (prio != 0) ? 1 : 1 - last;
        else if (cr)        sel = 0;
        else if (dr)        sel = 1;
        else                sel = -1;
        o.dg = (own == 1) || (own < 0 && lk);
        if (sel == 0) begin
            o.mrd = x.crd; o.mwr = x.cwr & ~x.crd;
            o.maddr = x.caddr; o.mwdata = x.cwdata; o.mbe = x.cbe;
            o.ccr = x.mcr; o.ccw = x.mcw; o.crdata = x.mcr ? x.mrdata : 32'h0;
        end else if (sel == 1) begin
            o.mrd = x.drd; o.mwr = x.dwr & ~x.drd;
            o.maddr = x.daddr; o.mwdata = x.dwdata; o.mbe = x.dbe;
            o.dcr = x.mcr; o.dcw = x.mcw; o.drdata = x.mcr ? x.mrdata : 32'h0;
        end
        return o;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        di[0] = '0; di[1] = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk("reset_state", k, dq[k], '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            m_own[k] = -1; m_lk[k] = 1'b0; m_last[k] = 1; rx[k] = '0;
        end
    endtask

    vec_t tbl[$];

    task automatic row(input bit crd, cwr, input logic [31:0] ca, input bit drd, dwr,
                       input logic [31:0] da, input bit lk, input bit mcr, mcw,
                       input logic [31:0] rd, input bit emr, emw, input logic [31:0] ea,
                       input bit eccr, input logic [31:0] ecrd, input bit edcw, edg);
        vec_t v;
        v.i = '0; v.o = '0;
        v.i.crd = crd; v.i.cwr = cwr; v.i.caddr = ca;
        v.i.drd = drd; v.i.dwr = dwr; v.i.daddr = da; v.i.dlock = lk;
        v.i.mcr = mcr; v.i.mcw = mcw; v.i.mrdata = rd;
        v.o.mrd = emr; v.o.mwr = emw; v.o.maddr = ea;
        v.o.ccr = eccr; v.o.crdata = ecrd; v.o.dcw = edcw; v.o.dg = edg;
        tbl.push_back(v);
    endtask

    initial begin
        out_t e;
        int   s [2];

        // Directed vectors on the round-robin DUT, one row per clock
        row(1,0,32'h100, 0,0,0, 0, 0,0,0,           1,0,32'h100, 0,0,           0,0);
        row(1,0,32'h100, 0,0,0, 0, 0,0,0,           1,0,32'h100, 0,0,           0,0);
        row(1,0,32'h100, 0,0,0, 0, 1,0,32'hDEADBEEF,1,0,32'h100, 1,32'hDEADBEEF,0,0);
        row(0,0,0,       0,0,0, 0, 0,0,0,           0,0,0,       0,0,           0,0);
        // Locked debug pair of writes with the core waiting
        row(1,0,32'h300, 0,1,32'h200, 1, 0,0,0,     0,1,32'h200, 0,0,           0,0);
        row(1,0,32'h300, 0,1,32'h200, 1, 0,1,0,     0,1,32'h200, 0,0,           1,1);
        row(1,0,32'h300, 0,0,0,       1, 0,0,0,     0,0,0,       0,0,           0,1);
        row(1,0,32'h300, 0,1,32'h204, 1, 0,0,0,     0,1,32'h204, 0,0,           0,1);
        row(1,0,32'h300, 0,1,32'h204, 1, 0,1,0,     0,1,32'h204, 0,0,           1,1);
        row(1,0,32'h300, 0,0,0,       1, 0,0,0,     0,0,0,       0,0,           0,1);
        row(1,0,32'h300, 0,0,0,       0, 0,0,0,     0,0,0,       0,0,           0,1);
        row(1,0,32'h300, 0,0,0,       0, 0,0,0,     1,0,32'h300, 0,0,           0,0);
        row(1,0,32'h300, 0,0,0,       0, 1,0,32'h1234, 1,0,32'h300, 1,32'h1234, 0,0);
        // Read and write together: read wins
        row(1,1,32'h400, 0,0,0,       0, 0,0,0,     1,0,32'h400, 0,0,           0,0);
        row(1,1,32'h400, 0,0,0,       0, 1,0,32'h55,1,0,32'h400, 1,32'h55,      0,0);
        row(0,0,0,       0,0,0,       0, 0,0,0,     0,0,0,       0,0,           0,0);

        do_reset();
        for (int r = 0; r < tbl.size(); r++) begin
            @(negedge clk);
            di[0] = tbl[r].i;
            #1;
            chk($sformatf("vec%0d", r), 0, dq[0], tbl[r].o);
        end

        // Both masters read continuously, slave answers one cycle after grant
        do_reset();
        for (int i = 0; i < 8; i++) begin
            int eo [2];
            eo[0] = i % 2; eo[1] = 1;
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                di[k] = '0;
                di[k].crd = 1'b1; di[k].caddr = 32'h1000;
                di[k].drd = 1'b1; di[k].daddr = 32'h2000;
            end
            #1;
            for (int k = 0; k < 2; k++)
                chk_b("alt_grant", k, dq[k].maddr, (eo[k] == 0) ? 32'h1000 : 32'h2000);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin di[k].mcr = 1'b1; di[k].mrdata = 32'(i); end
            #1;
            for (int k = 0; k < 2; k++)
                chk_b("alt_cpl", k, 32'({dq[k].ccr, dq[k].dcr}),
                      32'({eo[k] == 0, eo[k] == 1}));
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin di[k].drd = 1'b0; di[k].mcr = 1'b0; end
        #1;
        chk_b("core_after_dbg_drop", 1, 32'({dq[1].mrd, dq[1].dg}), 32'({1'b1, 1'b0}));
        chk_b("core_after_dbg_drop_addr", 1, dq[1].maddr, 32'h1000);

        // Zero-wait slave: core re-issues a read every other cycle
        do_reset();
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            di[0] = '0;
            di[0].crd = (j % 2 == 0); di[0].caddr = 32'h500;
            di[0].mcr = 1'b1; di[0].mrdata = 32'(j + 1);
            e = '0;
            if (j % 2 == 0) begin
                e.mrd = 1'b1; e.maddr = 32'h500; e.ccr = 1'b1; e.crdata = 32'(j + 1);
            end
            #1;
            chk("zero_wait", 0, dq[0], e);
        end

        // Reset in the middle of a core read, then a stray slave complete
        @(negedge clk);
        di[0] = '0; di[0].crd = 1'b1; di[0].caddr = 32'h100;
        #1;
        chk_b("pre_rst_grant", 0, 32'(dq[0].mrd), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk("in_reset", k, dq[k], '0);
        @(negedge clk);
        di[0].crd = 1'b0; di[0].mcr = 1'b1; di[0].mrdata = 32'hDEAD;
        rst_n = 1'b1;
        #1;
        chk("stray_cpl", 0, dq[0], '0);

        // Randomised traffic against the ownership model, both DUTs independent
        do_reset();
        for (int c = 0; c < 400; c++) begin
            out_t ex [2];
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                in_t x = rx[k];
                if (!(x.crd | x.cwr) && ($urandom % 3 == 0)) begin
                    int op = int'($urandom % 3);
                    x.crd = (op != 1); x.cwr = (op != 0);
                    x.caddr = $urandom; x.cwdata = $urandom; x.cbe = 4'($urandom);
                end
                if (!(x.drd | x.dwr) && ($urandom % 3 == 0)) begin
                    int op = int'($urandom % 3);
                    x.drd = (op != 1); x.dwr = (op != 0);
                    x.daddr = $urandom; x.dwdata = $urandom; x.dbe = 4'($urandom);
                end
                if ($urandom % 8 == 0) x.dlock = ~x.dlock;
                x.mrdata = $urandom; x.mcr = 1'b0; x.mcw = 1'b0;
                ex[k] = mdl(x, m_own[k], m_lk[k], m_last[k], k, s[k]);
                if (ex[k].mrd | ex[k].mwr) begin
                    if ($urandom % 3 == 0) begin x.mcr = ex[k].mrd; x.mcw = ex[k].mwr; end
                end else if ($urandom % 16 == 0) begin
                    x.mcr = 1'b1;
                end
                ex[k] = mdl(x, m_own[k], m_lk[k], m_last[k], k, s[k]);
                rx[k] = x;
                di[k] = x;
            end
            #1;
            for (int k = 0; k < 2; k++) chk("random", k, dq[k], ex[k]);
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                if (s[k] >= 0 && (rx[k].mcr | rx[k].mcw)) begin
                    if (s[k] == 0) begin rx[k].crd = 1'b0; rx[k].cwr = 1'b0; end
                    else           begin rx[k].drd = 1'b0; rx[k].dwr = 1'b0; end
                    m_own[k]  = -1;
                    m_lk[k]   = (s[k] == 1) && rx[k].dlock;
                    m_last[k] = s[k];
                end else if (s[k] >= 0) begin
                    m_own[k] = s[k];
                    m_lk[k]  = 1'b0;
                end else if (m_own[k] < 0 && m_lk[k] && !rx[k].dlock) begin
                    m_lk[k] = 1'b0;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the core's single memory port between two requesters: the core control unit (requester 0) and the debug module's system-bus access engine (requester 1).
- Sits between the core/debug masters and the memory slave.
- Holds a grant for the whole duration of one access, i.e. until the slave returns complete.
- Arbitrates round-robin or debug-priority, and supports a debug bus lock for multi-access atomic sequences.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports; byte-enable width is DATA_WIDTH/8.
- DBG_PRIORITY, 0, 0 = round-robin on contention; 1 = debug always wins contention.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- core_read / core_write  in  1  core access request; level, held until its complete
- core_addr  in  ADDR_WIDTH  core address
- core_wdata  in  DATA_WIDTH  core write data
- core_be  in  DATA_WIDTH/8  core byte enables
- core_rdata  out  DATA_WIDTH  read data to core
- core_complete_read / core_complete_write  out  1  one-cycle completion pulse to core
- dbg_read / dbg_write / dbg_addr / dbg_wdata / dbg_be  in  as core  debug access request
- dbg_lock  in  1  debug requests to keep ownership across accesses
- dbg_rdata / dbg_complete_read / dbg_complete_write  out  as core  debug response
- dbg_granted  out  1  debug currently owns the bus (registered)
- mem_read / mem_write / mem_addr / mem_wdata / mem_be  out  as core  to memory slave
- mem_rdata  in  DATA_WIDTH  from slave
- mem_complete_read / mem_complete_write  in  1  one-cycle slave completion

Behaviour:
- States:
  - IDLE: no owner.
  - OWN_CORE: owner = core.
  - OWN_DBG: owner = debug.
  - LOCKED: debug owns the bus between accesses.
- Registers: state, last_winner (reset = DBG, so the core wins the first tie).
- Reset (async, rst_n low): state = IDLE, last_winner = DBG.
  - All outputs are 0; mem_* outputs are 0 while no owner is selected.
  - Reset mid-access abandons the access; any late slave complete is ignored.
- IDLE, zero-latency arbitration:
  - The combinational winner is chosen from requesters with read|write asserted.
  - Sole requester wins.
  - On contention: DBG_PRIORITY=1 → debug; otherwise the requester ≠ last_winner.
  - The winner's signals drive mem_* in the same cycle.
  - Next state = OWN_<winner>, unless the slave completes in that same cycle (see the zero-wait rule below).
- OWN_x: mem_* = owner's signals.
  - Non-owner requests are held off: no complete, rdata = 0.
  - On mem_complete_read/write: pulse the owner's matching complete for exactly that cycle; owner rdata = mem_rdata in that cycle.
  - Next state is IDLE, or LOCKED if owner = DBG and dbg_lock = 1. Set last_winner = owner.
- Zero-wait slave (complete in the same cycle as the grant): handled identically; state returns through IDLE/LOCKED rules directly.
- Back-to-back: a requester holding read/write through its complete re-enters arbitration in the next cycle; no extra bubble beyond one arbitration cycle.
- LOCKED:
  - Core is held off.
  - A debug request is granted immediately (mem_* = dbg) and the state goes to OWN_DBG.
  - dbg_lock deasserted with no debug request → IDLE.
- Owner drops read/write before complete (protocol violation): grant is kept, mem_read/mem_write follow the owner (0), state is unchanged until complete; no assertion is required.
- read and write asserted together by one requester: read takes precedence; write is ignored.
- dbg_granted = (state ∈ {OWN_DBG, LOCKED}), registered.
- The arbiter never modifies addr/data/be; it is purely a mux plus sequencing.

Decomposition:
- Shared package mem_bus_pkg:
  - owner_e {OWNER_CORE, OWNER_DBG}
  - arb_state_e {ARB_IDLE, ARB_OWN_CORE, ARB_OWN_DBG, ARB_LOCKED}
- One natural sub-module: mem_bus_rr_pick (2-way winner from requests, last_winner, DBG_PRIORITY).

Test Plan:
- Reset, then core_read, addr 0x100; slave completes after 3 cycles with 0xDEADBEEF → mem_read high 3 cycles, core_complete_read one pulse, core_rdata 0xDEADBEEF, dbg outputs 0.
- Core and debug both read continuously, DBG_PRIORITY=0 → grants alternate CORE, DBG, CORE, DBG; each complete reaches only its owner.
- Same stimulus with DBG_PRIORITY=1 → debug wins every contention; core is granted only when dbg_read is low.
- dbg_lock=1 over two dbg_write accesses (0x200 then 0x204) while core_read is pending → core gets no grant until one cycle after dbg_lock falls; dbg_granted stays 1 throughout.
- Zero-wait slave (complete in the grant cycle), core reads back-to-back → one complete per 2 cycles; state returns to IDLE each time.
- rst_n pulsed low mid core read; slave completes after release → all outputs are 0 in reset; the stray complete produces no core/dbg complete pulse.
